// File: rtl/led_tail_fader.sv
// led_tail_fader: PWM output stage with a decaying "comet tail" per LED.
// Each channel snaps to full brightness while its input bit is high. After
// the bit drops, the brightness steps down on every decay tick. A shared PWM
// counter turns the duty value latched once per period into the pin level.
// Optional feature macro: LED_TAIL_GAMMA_EN. When it is defined, the latched
// duty is the squared brightness, which gives a more perceptual fade curve.

// Per-channel brightness, duty latch and PWM comparator.
module led_tail_ch #(
    parameter int PWM_BITS   = 8,
    parameter int DECAY_STEP = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                led_in,
    input  logic                fade_en,
    input  logic                decay_tick,
    input  logic                pwm_last,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out
);
    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [PWM_BITS-1:0] duty_q, duty_f;
    logic                led_q;

    // Brightness next state: bypass snap, input snap, saturating decay, hold.
    always_comb begin
        bright_d = bright_q;
        if (!fade_en)
            bright_d = led_in ? MAX : '0;
        else if (led_in)
            bright_d = MAX;
        else if (decay_tick)
            bright_d = (bright_q > STEP) ? (bright_q - STEP) : '0;
    end

`ifdef LED_TAIL_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    assign sq = {{PWM_BITS{1'b0}}, bright_q} * {{PWM_BITS{1'b0}}, bright_q};

    // Squared curve, truncated; full scale is pinned so MAX stays constant-on.
    always_comb begin
        duty_f = (bright_q == MAX) ? MAX : PWM_BITS'(sq >> PWM_BITS);
    end
`else
    // Linear mapping: duty is the brightness itself.
    always_comb begin
        duty_f = bright_q;
    end
`endif

    // State update. The duty is latched only at the period boundary, so a
    // brightness change in the middle of a period cannot glitch the pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bright_q <= '0;
            duty_q   <= '0;
            led_q    <= 1'b0;
        end else begin
            bright_q <= bright_d;
            if (pwm_last)
                duty_q <= duty_f;
            led_q <= fade_en ? ((duty_q == MAX) || (pwm_cnt < duty_q)) : led_in;
        end
    end

    assign led_out = led_q;
endmodule

// Top level: shared PWM counter, decay prescaler and per-channel array.
module led_tail_fader #(
    parameter int N_LED      = 4,
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 250000,
    parameter int DECAY_STEP = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [N_LED-1:0] led_in,
    input  logic             fade_en,
    output logic [N_LED-1:0] led_out,
    output logic             pwm_wrap
);
    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] MAX_M1   = MAX - 1'b1;
    localparam int                  DW       = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DW-1:0]       DEC_LAST = DW'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [DW-1:0]       dec_cnt_q;
    logic                pwm_wrap_q;
    logic                decay_tick;
    logic                pwm_last;

    assign decay_tick = (dec_cnt_q == DEC_LAST);
    assign pwm_last   = (pwm_cnt_q == MAX);

    // Free-running PWM counter. The wrap flag is registered one count early,
    // so it is high in exactly the cycle where the counter shows MAX.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pwm_cnt_q  <= '0;
            pwm_wrap_q <= 1'b0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_q + 1'b1;
            pwm_wrap_q <= (pwm_cnt_q == MAX_M1);
        end
    end

    // Decay prescaler. It counts 0..DECAY_DIV-1, and it ticks on its last count.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            dec_cnt_q <= '0;
        else
            dec_cnt_q <= decay_tick ? '0 : dec_cnt_q + 1'b1;
    end

    for (genvar g = 0; g < N_LED; g++) begin : g_ch
        led_tail_ch #(
            .PWM_BITS  (PWM_BITS),
            .DECAY_STEP(DECAY_STEP)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .led_in    (led_in[g]),
            .fade_en   (fade_en),
            .decay_tick(decay_tick),
            .pwm_last  (pwm_last),
            .pwm_cnt   (pwm_cnt_q),
            .led_out   (led_out[g])
        );
    end

    assign pwm_wrap = pwm_wrap_q;
endmodule

// File: tb/tb_led_tail_fader.sv
// Testbench for led_tail_fader with PWM_BITS=4, DECAY_DIV=2, DECAY_STEP=4.
// A cycle scoreboard holds the expected led_out/pwm_wrap for every edge.
// Directed steps also check the per-period high counts against constants.
module tb_led_tail_fader;
    localparam int NL   = 4;
    localparam int DIV  = 2;
    localparam int STEP = 4;
    localparam int MAXV = 15;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       fade_en = 1'b1;
    logic [3:0] led_in  = 4'b1111;
    logic [3:0] led_out;
    logic       pwm_wrap;

    typedef struct packed {
        logic [3:0] out;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_pwm = 0, m_dec = 0;
    int   m_bright[NL];
    int   m_duty[NL];
    int   hi[NL];

    led_tail_fader #(
        .N_LED(NL), .PWM_BITS(4), .DECAY_DIV(DIV), .DECAY_STEP(STEP)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .led_in  (led_in),
        .fade_en (fade_en),
        .led_out (led_out),
        .pwm_wrap(pwm_wrap)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int gam(input int b);
`ifdef LED_TAIL_GAMMA_EN
        return (b == MAXV) ? MAXV : ((b * b) >> 4);
`else
        return b;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge: predict the outputs from the current inputs, queue them,
    // and then compare them with what the DUT presents after the edge.
    task automatic tick();
        exp_t e;
        bit   tk;
        e = '0;
        if (sys_rst) begin
            m_pwm = 0;
            m_dec = 0;
            for (int i = 0; i < NL; i++) begin
                m_bright[i] = 0;
                m_duty[i]   = 0;
            end
        end else begin
            tk = (m_dec == DIV - 1);
            for (int i = 0; i < NL; i++)
                e.out[i] = fade_en ? ((m_duty[i] == MAXV) || (m_pwm < m_duty[i])) : led_in[i];
            e.wrap = (((m_pwm + 1) % (MAXV + 1)) == MAXV);
            for (int i = 0; i < NL; i++) begin
                if (m_pwm == MAXV) m_duty[i] = gam(m_bright[i]);
                if (!fade_en)         m_bright[i] = led_in[i] ? MAXV : 0;
                else if (led_in[i])   m_bright[i] = MAXV;
                else if (tk)          m_bright[i] = (m_bright[i] > STEP) ? m_bright[i] - STEP : 0;
            end
            m_pwm = (m_pwm + 1) % (MAXV + 1);
            m_dec = (m_dec + 1) % DIV;
        end
        sb.push_back(e);
        @(posedge sys_clk);
        #1;
        e = sb.pop_front();
        chk("sb_led_out", led_out, e.out);
        chk("sb_pwm_wrap", pwm_wrap, e.wrap);
        for (int i = 0; i < NL; i++)
            hi[i] += (led_out[i] === 1'b1) ? 1 : 0;
    endtask

    // Ticks until pwm_wrap is seen. The wait is bounded, and n returns the distance.
    task automatic wait_wrap(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (pwm_wrap !== 1'b1 && n < 40);
    endtask

    // Goes to the sample just after a duty-load edge. After this, each block of 16 ticks
    // covers exactly one PWM period of the newly loaded duty.
    task automatic align();
        int n;
        wait_wrap(n);
        chk("align_wrap", pwm_wrap, 1'b1);
        tick();
    endtask

    // One PWM period. It counts high cycles per channel. It can also drop or
    // raise led_in[0] before tick number drop_at or raise_at.
    task automatic period(input int drop_at, input int raise_at);
        for (int i = 0; i < NL; i++) hi[i] = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == drop_at)  led_in[0] = 1'b0;
            if (c == raise_at) led_in[0] = 1'b1;
            tick();
        end
    endtask

    // From full brightness, drop at tick c. The next period shows the reached
    // level. The one after that is dark, while led_in[0] is raised again.
    task automatic decay_run(input int c, input int lvl);
        period(c, -1);
        chk("decay_prev_full", hi[0], 16);
        period(-1, -1);
        chk("decay_level", hi[0], gam(lvl));
        period(-1, 0);
        chk("decay_dark", hi[0], 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NL; i++) begin
            m_bright[i] = 0;
            m_duty[i]   = 0;
            hi[i]       = 0;
        end

        // Reset with all inputs high. The outputs stay low.
        repeat (3) begin
            tick();
            chk("rst_led_out", led_out, 4'b0000);
            chk("rst_wrap", pwm_wrap, 1'b0);
        end
        sys_rst = 1'b0;
        led_in  = 4'b0000;
        fade_en = 1'b1;
        wait_wrap(n);
        chk("first_wrap_dist", n, 15);
        wait_wrap(n);
        chk("wrap_period", n, 16);
        tick();

        // Steady input gives a constant-on channel 0. The others stay dark.
        led_in = 4'b0001;
        period(-1, -1);
        period(-1, -1);
        chk("t2_on_cnt", hi[0], 16);
        chk("t2_others", hi[1] + hi[2] + hi[3], 0);

        // The decay levels 11, 7 and 3 are caught by the duty latch. A drop at
        // tick 0 reaches 0 within the period.
        decay_run(12, 11);
        decay_run(10, 7);
        decay_run(8, 3);
        period(0, -1);
        chk("t3_full_prev", hi[0], 16);
        period(-1, -1);
        chk("t3_floor0", hi[0], 0);
        period(-1, 0);
        chk("t3_hold0", hi[0], 0);

        // The latched duty 7 survives a raise in the middle of the period.
        period(10, -1);
        chk("t4_prev_full", hi[0], 16);
        period(-1, 8);
        chk("t4_mid_raise", hi[0], gam(7));
        period(-1, -1);
        chk("t4_next_full", hi[0], 16);

        // Bypass mode gives a one-cycle copy of the input.
        fade_en = 1'b0;
        led_in  = 4'b0001; tick(); chk("t5_byp0", led_out, 4'b0001);
        led_in  = 4'b0010; tick(); chk("t5_byp1", led_out, 4'b0010);
        led_in  = 4'b0100; tick(); chk("t5_byp2", led_out, 4'b0100);
        align();
        for (int c = 0; c < 16; c++) begin
            if (c == 14) begin
                fade_en = 1'b1;
                led_in  = 4'b0000;
            end
            tick();
        end
        period(-1, -1);
        chk("t5_resume_ch2", hi[2], 16);
        chk("t5_resume_ch0", hi[0], 0);

        // Reset in the middle of a fade, with channel 1 at 11 and duty 15.
        led_in = 4'b0010;
        period(-1, -1);
        period(-1, -1);
        chk("t6_ch1_full", hi[1], 16);
        led_in = 4'b0000;
        tick();
        tick();
        sys_rst = 1'b1;
        tick();
        chk("t6_rst_out", led_out, 4'b0000);
        chk("t6_rst_wrap", pwm_wrap, 1'b0);
        sys_rst = 1'b0;
        for (int i = 0; i < NL; i++) hi[i] = 0;
        wait_wrap(n);
        chk("t6_restart", n, 15);
        chk("t6_dark", hi[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
